ctrl_uart_rx: RTL and testbench
===============================

# ctrl_uart_rx

Buffered UART receiver for the control CPU's serial console. It samples `uart_rxd` with 16x oversampling and decodes 8N1 frames. Received bytes go into a first-word-fall-through FIFO. The control register block reads that FIFO through a pop strobe plus status flags. It replaces the unbuffered receive path: the register block reads `rx_dat` and status, and issues `pop` on a qmem read of the RX data register.

## Interface
Parameters:
- `OS_DIV`, default 27: clk cycles per oversample tick (50 MHz / 115200 / 16).
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `uart_rxd`  in  1: serial input, idle high, asynchronous to clk.
- `pop`  in  1: one-cycle strobe; removes the head byte.
- `clr_err`  in  1: one-cycle strobe; clears `overrun` and `frame_err`.
- `rx_dat`  out  8: FIFO head byte; valid while `rx_empty`=0.
- `rx_empty`  out  1: FIFO holds 0 entries.
- `rx_full`  out  1: FIFO holds 2^FIFO_AW entries.
- `rx_count`  out  FIFO_AW+1: number of entries.
- `overrun`  out  1: sticky; a complete byte was dropped because the FIFO was full.
- `frame_err`  out  1: sticky; stop bit sampled low.
- `rx_busy`  out  1: receiver state is not IDLE.

## Operation
- Input sync:
  - 2-flop synchronizer, reset to 2'b11.
  - One further delay flop `rxd_d`, reset 1.
  - A falling edge is synced=0 while `rxd_d`=1.
- Prescaler:
  - Counts OS_DIV-1 down to 0; `tick` fires when it is 0, then it reloads.
  - It is reloaded to OS_DIV-1 and `os_cnt` (4 bit) is cleared on falling-edge detection in IDLE.
- FSM states and transitions:
  - IDLE: on a falling edge, go to START.
  - START: on the tick where `os_cnt`==7, sample. Sample 0 → DATA, `os_cnt`←0, bit index←0. Sample 1 → IDLE (glitch rejected, nothing recorded).
  - DATA: on the tick where `os_cnt`==15, sample into the shift register, LSB first. After 8 bits → STOP.
  - STOP: on the tick where `os_cnt`==15, sample. Sample 1 → push the byte and go to IDLE. Sample 0 → set `frame_err`, drop the byte, go to BREAK.
  - BREAK: wait for synced=1, then go to IDLE, so that a held-low line is not decoded as 0x00 bytes.
- `os_cnt` increments on every tick outside IDLE and wraps at 16.
- FIFO:
  - Dual-pointer RAM with FIFO_AW-bit pointers and a FIFO_AW+1-bit count.
  - `rx_dat` = mem[rd_ptr], combinational.
  - Push while full without a same-cycle pop: drop the byte and set `overrun`.
  - Push and pop in the same cycle: both happen, count unchanged, including when full (no overrun) and when empty (the push wins; the pop is ignored because `rx_empty`=1).
  - Pop while empty: ignored.
  - Pointers wrap modulo 2^FIFO_AW.
- Sticky flags:
  - `clr_err` clears both flags.
  - If a set and a clear occur in the same cycle, the set wins.
- Reset, at any time including mid-frame:
  - FSM→IDLE, FIFO emptied (pointers and count 0).
  - Flags 0, prescaler reloaded, partial byte discarded.

## Timing
- Reset values: `rx_empty`=1, `rx_full`=0, `rx_count`=0, `overrun`=0, `frame_err`=0, `rx_busy`=0. `rx_dat` is undefined (RAM is not reset).
- Sync latency: 3 clk from a `uart_rxd` edge to falling-edge detection.
- First sample point is 8·OS_DIV clk after detection; later sample points are every 16·OS_DIV clk.
- Stop sample is at detection + (8+9·16)·OS_DIV = 4104 clk at default.
- Push takes effect on the clk edge after the stop sample. `rx_empty`/`rx_count` update 1 clk later.
- Pop: `rx_dat`, `rx_count` and `rx_empty` reflect the new head 1 clk after the `pop` cycle.
- A new start edge is accepted in the cycle after returning to IDLE, which allows back-to-back frames with a 1-bit stop.

## Test plan
- Single byte: send 0xA5 at 115200 baud, default params.
  - `rx_empty` falls 4105–4112 clk after the start edge.
  - `rx_dat`=0xA5, `rx_count`=1.
  - After `pop`: `rx_empty`=1, `rx_count`=0.
- Back-to-back fill:
  - Send 0x00..0x10 (17 bytes) without popping.
  - `rx_full`=1 after byte 16 and `overrun`=1 after byte 17.
  - Popping 16 times yields 0x00..0x0F in order.
- Simultaneous push and pop while full: pop on the exact push cycle of byte 17.
  - `overrun` stays 0, `rx_count` stays 16.
  - The tail is 0x10 and the head becomes 0x01.
- Framing:
  - Send 0x3C with the stop bit low, then hold the line low for 3 bit times.
  - `frame_err`=1, no push, FSM stays in BREAK.
  - After the line returns high, 0x55 is received correctly.
  - `clr_err` clears `frame_err`.
- Glitch: a 4·OS_DIV-clk low pulse on an idle line produces no push, `rx_busy` returns to 0, and flags stay 0.
- Reset mid-frame:
  - Assert `rst` during bit 4 of 0xFF while the FIFO holds 2 bytes.
  - All outputs return to their reset values immediately.
  - The next 0x81 is received correctly.

Source files
------------

// File: rtl/ctrl_uart_rx.sv
// Buffered 8N1 UART receiver: 16x oversampled decoder feeding a first-word-fall-through FIFO.
// The register block reads the head byte and status flags, and pops on a data-register read.
module ctrl_uart_rx #(
    parameter int unsigned OS_DIV  = 27,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rxd,
    input  logic               pop,
    input  logic               clr_err,
    output logic [7:0]         rx_dat,
    output logic               rx_empty,
    output logic               rx_full,
    output logic [FIFO_AW:0]   rx_count,
    output logic               overrun,
    output logic               frame_err,
    output logic               rx_busy
);
    localparam int unsigned PSW   = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

    state_t             state, state_nxt;
    logic [1:0]         sync_q;
    logic               rxd_d;
    logic               synced_c, fall_c, tick_c;
    logic [PSW-1:0]     ps_cnt;
    logic [3:0]         os_cnt, os_nxt;
    logic [2:0]         bit_idx, bit_nxt;
    logic [7:0]         shift_q, shift_nxt;
    logic               push_q, push_nxt;
    logic               ferr_set_c, ps_reload_c;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               do_push_c, do_pop_c, ovr_set_c;
    logic [CW-1:0]      count_nxt_c;

    assign synced_c = sync_q[1];
    assign fall_c   = !synced_c && rxd_d;
    assign tick_c   = (ps_cnt == '0);

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            rxd_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
            rxd_d  <= synced_c;
        end
    end

    // Oversample prescaler, re-phased to each start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ps_cnt <= PSW'(OS_DIV - 1);
        else if (ps_reload_c || tick_c)
            ps_cnt <= PSW'(OS_DIV - 1);
        else
            ps_cnt <= ps_cnt - PSW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            os_cnt  <= 4'd0;
            bit_idx <= 3'd0;
            shift_q <= 8'd0;
            push_q  <= 1'b0;
            rx_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            os_cnt  <= os_nxt;
            bit_idx <= bit_nxt;
            shift_q <= shift_nxt;
            push_q  <= push_nxt;
            rx_busy <= (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        state_nxt   = state;
        os_nxt      = os_cnt;
        bit_nxt     = bit_idx;
        shift_nxt   = shift_q;
        push_nxt    = 1'b0;
        ferr_set_c  = 1'b0;
        ps_reload_c = 1'b0;
        if (state != S_IDLE && tick_c)
            os_nxt = os_cnt + 4'd1;
        case (state)
            S_IDLE: begin
                if (fall_c) begin
                    state_nxt   = S_START;
                    ps_reload_c = 1'b1;
                    os_nxt      = 4'd0;
                end
            end
            S_START: begin
                if (tick_c && os_cnt == 4'd7) begin
                    if (!synced_c) begin
                        state_nxt = S_DATA;
                        os_nxt    = 4'd0;
                        bit_nxt   = 3'd0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick_c && os_cnt == 4'd15) begin
                    shift_nxt = {synced_c, shift_q[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_c && os_cnt == 4'd15) begin
                    if (synced_c) begin
                        push_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_nxt  = S_BRK;
                    end
                end
            end
            S_BRK: begin
                // Hold off until the line idles so a held-low line is not decoded as 0x00
                if (synced_c)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO: pop only when non-empty; a push into a full FIFO needs a same-cycle pop
    assign do_pop_c    = pop && !rx_empty;
    assign do_push_c   = push_q && (!rx_full || do_pop_c);
    assign ovr_set_c   = push_q && rx_full && !do_pop_c;
    assign count_nxt_c = rx_count + CW'(do_push_c) - CW'(do_pop_c);
    assign rx_dat      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push_c)
            mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_count  <= '0;
            rx_empty  <= 1'b1;
            rx_full   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push_c)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (do_pop_c)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            rx_count <= count_nxt_c;
            rx_empty <= (count_nxt_c == '0);
            rx_full  <= (count_nxt_c == CW'(DEPTH));
            if (ovr_set_c)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
            if (ferr_set_c)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_uart_rx.sv
// Self-checking bench for ctrl_uart_rx: serial frames against a queue-based receive model.
module tb_ctrl_uart_rx;
    localparam int unsigned OS     = 4;
    localparam int unsigned AW     = 4;
    localparam int          DEPTH  = 16;
    localparam int          BIT    = 16 * OS;
    localparam int          FRAME  = 10 * BIT;
    localparam int          PUSH_C = 3 + 152 * OS;

    logic        clk = 1'b0;
    logic        rst, uart_rxd, pop, clr_err;
    logic [7:0]  rx_dat;
    logic        rx_empty, rx_full, overrun, frame_err, rx_busy;
    logic [AW:0] rx_count;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  mq[$];
    logic        m_ovr = 1'b0;
    logic        m_ferr = 1'b0;

    ctrl_uart_rx #(.OS_DIV(OS), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .pop(pop), .clr_err(clr_err),
        .rx_dat(rx_dat), .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
        .overrun(overrun), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Drive one frame; optionally pop on the cycle the byte enters the FIFO
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_on_push);
        logic [9:0] fr;
        logic       popped, was_full;
        fr = {stop, b, 1'b0};
        for (int c = 0; c < FRAME; c++) begin
            @(posedge clk); #1;
            uart_rxd = fr[c / BIT];
            pop = pop_on_push && (c == PUSH_C);
        end
        pop = 1'b0;
        if (stop) begin
            popped   = pop_on_push && (mq.size() > 0);
            was_full = (mq.size() == DEPTH);
            if (popped) void'(mq.pop_front());
            if (was_full && !popped) m_ovr = 1'b1;
            else mq.push_back(b);
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic pop_once();
        @(posedge clk); #1 pop = 1'b1;
        @(posedge clk); #1 pop = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic clear_errs();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; uart_rxd = 1'b1; pop = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", rx_empty); end
        n_chk++; if (rx_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", rx_full); end
        n_chk++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rx_count); end
        n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_single();
        int t = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                @(posedge clk);
                while (rx_empty === 1'b1 && t < FRAME) begin
                    @(posedge clk); t++; #2;
                end
            end
        join
        n_chk++;
        if (t < 152 * OS + 1 || t > 152 * OS + 8) begin
            n_fail++; $display("FAIL single_latency: got %0d clk want %0d..%0d", t, 152 * OS + 1, 152 * OS + 8);
        end
        n_chk++; if (rx_dat !== 8'hA5) begin n_fail++; $display("FAIL single_dat: got %h want a5", rx_dat); end
        n_chk++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", rx_count); end
        pop_once();
        n_chk++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL single_pop_empty: got %b want 1", rx_empty); end
        n_chk++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL single_pop_count: got %0d want 0", rx_count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == 15) begin
                n_chk++; if (rx_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", rx_full); end
                n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovr: got %b want 0", overrun); end
            end
        end
        n_chk++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL fill_overrun: got %b want %b", overrun, m_ovr); end
        n_chk++; if (rx_count !== 5'(mq.size())) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", rx_count, mq.size()); end
        for (int i = 0; i < 16; i++) begin
            n_chk++; if (rx_dat !== mq[0]) begin n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", i, rx_dat, mq[0]); end
            pop_once();
        end
        n_chk++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained: got %b want 1", rx_empty); end
        clear_errs();
        n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fill_clr_ovr: got %b want 0", overrun); end
    endtask

    task automatic test_simul_push_pop();
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0);
        send_frame(8'h10, 1'b1, 1'b1);
        n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL simul_overrun: got %b want 0", overrun); end
        n_chk++; if (rx_count !== 5'(mq.size())) begin n_fail++; $display("FAIL simul_count: got %0d want %0d", rx_count, mq.size()); end
        n_chk++; if (rx_dat !== 8'h01) begin n_fail++; $display("FAIL simul_head: got %h want 01", rx_dat); end
        while (mq.size() > 1) begin
            n_chk++; if (rx_dat !== mq[0]) begin n_fail++; $display("FAIL simul_order: got %h want %h", rx_dat, mq[0]); end
            pop_once();
        end
        n_chk++; if (rx_dat !== 8'h10) begin n_fail++; $display("FAIL simul_tail: got %h want 10", rx_dat); end
        pop_once();
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3 * BIT) @(posedge clk);
        #1;
        n_chk++; if (frame_err !== m_ferr) begin n_fail++; $display("FAIL frame_err_set: got %b want %b", frame_err, m_ferr); end
        n_chk++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL frame_no_push: got %b want 1", rx_empty); end
        n_chk++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL frame_break_busy: got %b want 1", rx_busy); end
        uart_rxd = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        send_frame(8'h55, 1'b1, 1'b0);
        n_chk++; if (rx_dat !== 8'h55) begin n_fail++; $display("FAIL frame_recover_dat: got %h want 55", rx_dat); end
        n_chk++; if (rx_count !== 5'(mq.size())) begin n_fail++; $display("FAIL frame_recover_count: got %0d want %0d", rx_count, mq.size()); end
        clear_errs();
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_clr: got %b want 0", frame_err); end
        pop_once();
    endtask

    task automatic test_glitch();
        @(posedge clk); #1 uart_rxd = 1'b0;
        repeat (4 * OS) @(posedge clk);
        #1 uart_rxd = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
        n_chk++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL glitch_no_push: got %b want 1", rx_empty); end
        n_chk++; if ({overrun, frame_err} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags: got %b want 00", {overrun, frame_err}); end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] fr;
        send_frame(8'($urandom), 1'b1, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b0);
        fr = {1'b1, 8'hFF, 1'b0};
        for (int c = 0; c < 5 * BIT + BIT / 2; c++) begin
            @(posedge clk); #1 uart_rxd = fr[c / BIT];
        end
        rst = 1'b1;
        #1;
        mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        n_chk++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b want 1", rx_empty); end
        n_chk++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", rx_count); end
        n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", rx_busy); end
        n_chk++; if ({rx_full, overrun, frame_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b want 000", {rx_full, overrun, frame_err}); end
        uart_rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * BIT) @(posedge clk);
        send_frame(8'h81, 1'b1, 1'b0);
        n_chk++; if (rx_dat !== 8'h81) begin n_fail++; $display("FAIL midrst_next_dat: got %h want 81", rx_dat); end
        n_chk++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL midrst_next_count: got %0d want 1", rx_count); end
        pop_once();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom), 1'b1, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                n_chk++; if (rx_dat !== mq[0]) begin n_fail++; $display("FAIL rand_head[%0d]: got %h want %h", i, rx_dat, mq[0]); end
                pop_once();
            end
            n_chk++; if (rx_count !== 5'(mq.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, rx_count, mq.size()); end
        end
        while (mq.size() > 0) begin
            n_chk++; if (rx_dat !== mq[0]) begin n_fail++; $display("FAIL rand_drain: got %h want %h", rx_dat, mq[0]); end
            pop_once();
        end
        n_chk++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rand_empty: got %b want 1", rx_empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simul_push_pop();
        test_framing();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
